// File: rtl/mem_arbiter.sv
// Shares one memory command port between instruction fetch and data load/store.
// Each access runs arbitrate -> issue -> wait for m_done_i (or watchdog) -> done pulse to the winner.
//
// state  | meaning
// S_IDLE | no access in flight, m_* outputs held at zero
// S_BUSY | command held on m_*, waiting for m_done_i or watchdog expiry
module mem_arbiter #(
  parameter int unsigned TIMEOUT  = 64,
  parameter bit          DATA_PRI = 1'b0
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        f_req_i,
  input  logic [13:0] f_addr_i,
  output logic        f_done_o,
  output logic [7:0]  f_rdata_o,
  output logic        f_err_o,
  input  logic        d_req_i,
  input  logic        d_we_i,
  input  logic [13:0] d_addr_i,
  input  logic [15:0] d_wdata_i,
  output logic        d_done_o,
  output logic [7:0]  d_rdata_o,
  output logic        d_err_o,
  output logic        m_store_o,
  output logic        m_load_o,
  output logic [15:0] m_result_o,
  output logic [13:0] m_addr_o,
  input  logic        m_done_i,
  input  logic [7:0]  m_rdata_i,
  output logic        busy_o,
  output logic        grant_id_o
);

  localparam int unsigned   CW       = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_e;

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic          last_q;
  logic          grant_q;
  logic          m_store_q;
  logic          m_load_q;
  logic [13:0]   m_addr_q;
  logic [15:0]   m_result_q;
  logic          f_done_q;
  logic          f_err_q;
  logic [7:0]    f_rdata_q;
  logic          d_done_q;
  logic          d_err_q;
  logic [7:0]    d_rdata_q;

  logic          req_any_d;
  logic          grant_d;
  logic [7:0]    rdata_d;

  // grant_d: 0 = fetch, 1 = data; last_q tracks the port last served successfully
  always_comb begin
    req_any_d = f_req_i | d_req_i;
    grant_d   = d_req_i;
    if (f_req_i && d_req_i) begin
      grant_d = DATA_PRI ? 1'b1 : ~last_q;
    end
    rdata_d = m_store_q ? 8'h00 : m_rdata_i;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      last_q     <= 1'b1;
      grant_q    <= 1'b0;
      m_store_q  <= 1'b0;
      m_load_q   <= 1'b0;
      m_addr_q   <= '0;
      m_result_q <= '0;
      f_done_q   <= 1'b0;
      f_err_q    <= 1'b0;
      f_rdata_q  <= '0;
      d_done_q   <= 1'b0;
      d_err_q    <= 1'b0;
      d_rdata_q  <= '0;
    end else begin
      f_done_q <= 1'b0;
      f_err_q  <= 1'b0;
      d_done_q <= 1'b0;
      d_err_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req_any_d) begin
            state_q    <= S_BUSY;
            cnt_q      <= '0;
            grant_q    <= grant_d;
            m_addr_q   <= grant_d ? d_addr_i : f_addr_i;
            m_result_q <= grant_d ? d_wdata_i : 16'h0000;
            m_store_q  <= grant_d & d_we_i;
            m_load_q   <= ~(grant_d & d_we_i);
          end
        end
        S_BUSY: begin
          if (m_done_i || (cnt_q == CNT_LAST)) begin
            // m_done_i wins over a same-cycle watchdog expiry
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            m_store_q  <= 1'b0;
            m_load_q   <= 1'b0;
            m_addr_q   <= '0;
            m_result_q <= '0;
            if (m_done_i) begin
              last_q <= grant_q;
            end
            if (grant_q) begin
              d_done_q  <= 1'b1;
              d_err_q   <= ~m_done_i;
              d_rdata_q <= m_done_i ? rdata_d : 8'h00;
            end else begin
              f_done_q  <= 1'b1;
              f_err_q   <= ~m_done_i;
              f_rdata_q <= m_done_i ? rdata_d : 8'h00;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy_o     = (state_q == S_BUSY);
  assign grant_id_o = grant_q;
  assign m_store_o  = m_store_q;
  assign m_load_o   = m_load_q;
  assign m_addr_o   = m_addr_q;
  assign m_result_o = m_result_q;
  assign f_done_o   = f_done_q;
  assign f_err_o    = f_err_q;
  assign f_rdata_o  = f_rdata_q;
  assign d_done_o   = d_done_q;
  assign d_err_o    = d_err_q;
  assign d_rdata_o  = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and randomized bench for mem_arbiter against a transaction-level model of
// arbitration, watchdog and completion; a fixed-priority instance runs in lockstep.
module tb_mem_arbiter;
  localparam int TO = 8;

  logic        clk, reset;
  logic        f_req, d_req, d_we, m_done;
  logic [13:0] f_addr, d_addr;
  logic [15:0] d_wdata;
  logic [7:0]  m_rdata;

  logic        f_done, f_err, d_done, d_err, m_store, m_load, busy, grant_id;
  logic [7:0]  f_rdata, d_rdata;
  logic [15:0] m_result;
  logic [13:0] m_addr;

  logic        p_f_done, p_f_err, p_d_done, p_d_err, p_m_store, p_m_load, p_busy, p_grant;
  logic [7:0]  p_f_rdata, p_d_rdata;
  logic [15:0] p_m_result;
  logic [13:0] p_m_addr;

  int checks = 0;
  int errors = 0;
  logic m_last;   // model: 1 when data was the last port served successfully
  bit chk_pri = 1'b0;

  mem_arbiter #(.TIMEOUT(TO), .DATA_PRI(1'b0)) u_dut (
    .clk_i(clk), .reset_i(reset),
    .f_req_i(f_req), .f_addr_i(f_addr), .f_done_o(f_done), .f_rdata_o(f_rdata), .f_err_o(f_err),
    .d_req_i(d_req), .d_we_i(d_we), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
    .d_done_o(d_done), .d_rdata_o(d_rdata), .d_err_o(d_err),
    .m_store_o(m_store), .m_load_o(m_load), .m_result_o(m_result), .m_addr_o(m_addr),
    .m_done_i(m_done), .m_rdata_i(m_rdata), .busy_o(busy), .grant_id_o(grant_id)
  );

  mem_arbiter #(.TIMEOUT(TO), .DATA_PRI(1'b1)) u_pri (
    .clk_i(clk), .reset_i(reset),
    .f_req_i(f_req), .f_addr_i(f_addr), .f_done_o(p_f_done), .f_rdata_o(p_f_rdata), .f_err_o(p_f_err),
    .d_req_i(d_req), .d_we_i(d_we), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
    .d_done_o(p_d_done), .d_rdata_o(p_d_rdata), .d_err_o(p_d_err),
    .m_store_o(p_m_store), .m_load_o(p_m_load), .m_result_o(p_m_result), .m_addr_o(p_m_addr),
    .m_done_i(m_done), .m_rdata_i(m_rdata), .busy_o(p_busy), .grant_id_o(p_grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000 ns");
    $fatal(1, "simulation time limit");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk(tag, 64'({busy, m_store, m_load, m_addr, m_result, f_done, d_done, f_err, d_err}), 64'h0);
  endtask

  // One access: m_done arrives in busy cycle kdone (0 = never). Requests must be set up by the caller.
  task automatic do_access(input int kdone, input logic [7:0] rd, input string tag);
    logic win, st, ok;
    logic [13:0] ea;
    logic [15:0] ew;
    logic [7:0]  erd;
    if (f_req && d_req) win = ~m_last;
    else win = d_req;
    st = win & d_we;
    ea = win ? d_addr : f_addr;
    ew = d_wdata;
    ok = (kdone >= 1) && (kdone <= TO);
    erd = (ok && !st) ? rd : 8'h00;
    @(posedge clk); #1;
    for (int c = 1; c <= TO; c++) begin
      chk({tag, "_busy"},
          64'({busy, m_store, m_load, m_addr, (win ? m_result : 16'h0), grant_id, f_done, d_done}),
          64'({1'b1, st, ~st, ea, (win ? ew : 16'h0), win, 1'b0, 1'b0}));
      if (c == kdone) begin
        m_done = 1'b1;
        m_rdata = rd;
      end
      @(posedge clk); #1;
      m_done = 1'b0;
      m_rdata = 8'($urandom);
      if (c == kdone) break;
    end
    chk({tag, "_done"},
        64'({busy, m_store, m_load, m_addr, m_result, grant_id, f_done, f_err,
             (win ? 8'h0 : f_rdata), d_done, d_err, (win ? d_rdata : 8'h0)}),
        64'({1'b0, 1'b0, 1'b0, 14'h0, 16'h0, win, ~win, ~win & ~ok,
             (win ? 8'h0 : erd), win, win & ~ok, (win ? erd : 8'h0)}));
    if (chk_pri) chk({tag, "_pri"}, 64'({p_busy, p_grant, p_d_done, p_f_done}), 64'(4'b0110));
    if (ok) m_last = win;
    if (win) d_req = 1'b0;
    else f_req = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      m_done = 1'($urandom);
      m_rdata = 8'($urandom);
      @(posedge clk); #1;
      m_done = 1'b0;
      chk_quiet("idle");
    end
  endtask

  initial begin
    reset = 1'b1;
    f_req = 1'b0; d_req = 1'b0; d_we = 1'b0; m_done = 1'b0;
    f_addr = '0; d_addr = '0; d_wdata = '0; m_rdata = '0;
    m_last = 1'b1;
    #3;
    chk("reset", 64'({busy, m_store, m_load, m_addr, m_result, f_done, d_done, f_err, d_err,
                      f_rdata, d_rdata, grant_id}), 64'h0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    idle(2);

    // single fetch
    f_req = 1'b1; f_addr = 14'h0123;
    do_access(2, 8'hA5, "fetch");
    idle(1);

    // store to top of memory
    d_req = 1'b1; d_we = 1'b1; d_addr = 14'h3FFF; d_wdata = 16'hBEEF;
    do_access(3, 8'h77, "store");
    idle(1);

    // contention with both requests held: round-robin alternates, fixed priority keeps data
    d_we = 1'b0; d_addr = 14'h0200; f_addr = 14'h0100; d_wdata = 16'h1234;
    f_req = 1'b1; d_req = 1'b1;
    chk_pri = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("rr_grant_pred", 64'(m_last), 64'(i % 2 == 0));
      do_access(1 + i, 8'(8'h10 + i), "rr");
      f_req = 1'b1; d_req = 1'b1;
    end
    chk_pri = 1'b0;
    f_req = 1'b0; d_req = 1'b0;
    idle(2);

    // watchdog: never, late, and same-cycle completion
    d_req = 1'b1; d_we = 1'b0; d_addr = 14'h1234;
    do_access(0, 8'h55, "tmo");
    d_req = 1'b1;
    do_access(TO - 1, 8'h66, "tmo7");
    d_req = 1'b1;
    do_access(TO, 8'h99, "tmo8");
    idle(1);

    // reset in the second busy cycle
    f_req = 1'b1; f_addr = 14'h0AAA;
    @(posedge clk); #1;
    chk("rst_b1", 64'({busy, m_load}), 64'(2'b11));
    @(posedge clk); #3;
    reset = 1'b1;
    #1;
    chk("rst_async", 64'({busy, m_store, m_load, m_addr, m_result, f_done, d_done, f_err, d_err,
                          f_rdata, d_rdata, grant_id}), 64'h0);
    #2;
    reset = 1'b0;
    m_last = 1'b1;
    d_req = 1'b1; d_we = 1'b0; d_addr = 14'h0555;
    do_access(1, 8'h3C, "rst_tie");
    do_access(2, 8'hC3, "rst_loser");
    idle(1);

    // randomized traffic; held requests persist until served
    for (int i = 0; i < 60; i++) begin
      if (!f_req && $urandom_range(0, 1) == 1) begin
        f_req = 1'b1; f_addr = 14'($urandom);
      end
      if (!d_req && $urandom_range(0, 1) == 1) begin
        d_req = 1'b1; d_we = 1'($urandom); d_addr = 14'($urandom); d_wdata = 16'($urandom);
      end
      if (!f_req && !d_req) begin
        f_req = 1'b1; f_addr = 14'($urandom);
      end
      do_access(int'($urandom_range(0, 11)), 8'($urandom), "rnd");
      if (!f_req && !d_req && $urandom_range(0, 3) == 0) idle(1);
    end
    while (f_req || d_req) do_access(1, 8'($urandom), "drain");
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the single memory interface (store/load, 16-bit result, 14-bit address, mem_done, 8-bit read data) between the instruction-fetch port and the data load/store port. It sits between the core's fetch/execute logic and the memory-interface block. Each access is sequenced end to end: arbitrate, issue the command, wait for mem_done, return data to the winner. A watchdog timeout stops a hung memory from stalling the core.

## Interface
- TIMEOUT, 64: maximum BUSY cycles without m_done before the access aborts. Legal range is ≥2.
- DATA_PRI, 0: 0 selects round-robin; 1 selects fixed priority for the data port.
- clk  in  1  single clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- f_req  in  1  fetch request; held until f_done.
- f_addr  in  14  fetch address.
- f_done  out  1  one-cycle completion pulse to fetch.
- f_rdata  out  8  fetch read data; valid while f_done=1.
- f_err  out  1  pulses with f_done when the access timed out.
- d_req  in  1  data request; held until d_done.
- d_we  in  1  1 selects store; 0 selects load.
- d_addr  in  14  data address.
- d_wdata  in  16  store data.
- d_done  out  1  one-cycle completion pulse to data.
- d_rdata  out  8  load data; valid while d_done=1.
- d_err  out  1  pulses with d_done on timeout.
- m_store  out  1  store command to the memory interface.
- m_load  out  1  load command to the memory interface.
- m_result  out  16  store data to the memory interface.
- m_addr  out  14  address to the memory interface.
- m_done  in  1  completion from the memory interface.
- m_rdata  in  8  read data from the memory interface; sampled on the m_done cycle.
- busy  out  1  high while in BUSY.
- grant_id  out  1  owner of the current or last access: 0 = fetch, 1 = data.

## Operation
- States: IDLE and BUSY.
- IDLE with no request: stay in IDLE; all m_* outputs 0.
- IDLE with at least one request:
  - Select the winner.
  - Latch its address, we, and wdata into the m_* registers. Fetch is always a load.
  - Set grant_id, clear the timeout counter, go to BUSY.
- Arbitration, DATA_PRI=0:
  - Single requester wins.
  - Both requesting: the port not granted last time wins.
  - The last-grant flag resets to data, so fetch wins the first tie.
- Arbitration, DATA_PRI=1: data wins every tie.
- BUSY:
  - Exactly one of m_store/m_load is held high.
  - m_addr and m_result are held constant.
  - The counter increments each cycle that m_done=0.
- m_done=1 in BUSY:
  - Capture m_rdata into the winner's rdata register.
  - Pulse the winner's done on the next cycle. err stays 0.
  - Drop m_store/m_load, return to IDLE.
  - The last-grant flag updates to the winner.
- Timeout: counter reaches TIMEOUT−1 while m_done=0.
  - Return to IDLE.
  - Pulse the winner's done and err together; rdata=0.
  - Drop the m_* commands.
- m_done and timeout in the same cycle: treated as success, err=0.
- m_done while IDLE: ignored.
- Request inputs are ignored while BUSY. The loser keeps its req asserted and is served next.
- A req still high in the cycle its done pulses counts as a new request.
- Stores return rdata=0.

## Timing
- Reset values:
  - State IDLE, counter 0, last-grant = data, grant_id 0.
  - busy, m_store, m_load, f_done, d_done, f_err, d_err: 0.
  - m_addr, m_result, f_rdata, d_rdata: 0.
- All outputs are registered.
- Issue latency: req high at IDLE edge N → m_load/m_store and busy high from cycle N+1.
- Completion: m_done high at edge M → done/rdata valid and m_* low in cycle M+1, state IDLE.
- Back-to-back: next command asserts at M+2 at the earliest. Minimum access is 3 cycles from req to done.
- Timeout: err/done asserts TIMEOUT cycles after busy rose.
- Reset during BUSY:
  - Commands drop asynchronously.
  - No done or err pulse is generated.
  - The interrupted requester must re-request.

## Test plan
- Reset: assert reset mid-run → all outputs 0 immediately; first tie after release goes to fetch.
- Single fetch: f_req, f_addr=0x0123; m_done after 2 cycles with m_rdata=0xA5 → m_load=1 with m_addr=0x0123, then f_done=1 with f_rdata=0xA5 for exactly one cycle; m_store never high.
- Data store: d_we=1, d_addr=0x3FFF, d_wdata=0xBEEF → m_store=1, m_result=0xBEEF, m_addr=0x3FFF held until m_done; then d_done=1, d_rdata=0.
- Contention, DATA_PRI=0: f_req and d_req held continuously → grants alternate F, D, F, D, each done pulse matches grant_id; repeat with DATA_PRI=1 → data always wins while d_req is held.
- Timeout: TIMEOUT=8, m_done never asserts → exactly 8 busy cycles, then d_err=1 with d_done=1; m_done on cycle 7 instead → success, err=0.
- Reset mid-access: reset in the 2nd BUSY cycle → m_load drops asynchronously, no done pulse; after release, re-request completes normally.
